// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite bundle with 32-bit address/data, 4-bit write mask and 2-bit response.
// Modports: master drives ar/aw/w valid+payload and r/b ready; slave is the mirror image.
interface axi_lite_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_xbar.sv
// axi_lite_xbar: 1-to-NS AXI4-Lite address-decoding crossbar with an internal DECERR responder.
// Ports: clk, reset (synchronous, active-high); m = upstream master (axi_lite_if.slave);
// s[NS] = downstream slaves (axi_lite_if.master); difftest_skip = one-cycle pulse after a
// completed device access, present only when AXI_XBAR_DIFFTEST_SKIP_EN is defined.
// Slave i owns bits [32*i +: 32] of SLV_BASE/SLV_MASK: slave 0 is SRAM, 1 and 2 are MMIO.
module axi_lite_xbar #(
    parameter int               NS         = 3,
    parameter logic [NS*32-1:0] SLV_BASE   = {32'ha000_0048, 32'ha000_03f8, 32'h8000_0000},
    parameter logic [NS*32-1:0] SLV_MASK   = {32'hffff_fff8, 32'hffff_fff8, 32'hf800_0000},
    parameter logic [NS-1:0]    SLV_IS_DEV = 3'b110
) (
    input  logic       clk,
    input  logic       reset,
    axi_lite_if.slave  m,
    axi_lite_if.master s [NS]
`ifdef AXI_XBAR_DIFFTEST_SKIP_EN
    ,
    output logic       difftest_skip
`endif
);
    localparam int SW = NS > 1 ? $clog2(NS) : 1;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ERR} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP, W_ERR} w_state_e;
    r_state_e      r_state_q, r_state_d;
    w_state_e      w_state_q, w_state_d;
    logic [SW-1:0] sel_r_q, sel_r_d, sel_w_q, sel_w_d, ar_sel, aw_sel, ws;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d, err_q, err_d;
    logic          ar_hit, aw_hit, ar_go, r_go, w_idle, w_xfer, w_xerr, aw_go, wd_go, b_go;
    logic          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [NS-1:0] s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [31:0]   s_rdata [NS];
    logic [1:0]    s_rresp [NS];
    logic [1:0]    s_bresp [NS];

    // Scan high to low so the lowest matching index is the one left standing.
    function automatic logic [SW:0] decode(input logic [31:0] a);
        logic [SW:0] d;
        d = '0;
        for (int i = NS - 1; i >= 0; i--)
            if ((a & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) d = {1'b1, SW'(i)};
        return d;
    endfunction

    assign {ar_hit, ar_sel} = decode(m.araddr);
    assign {aw_hit, aw_sel} = decode(m.awaddr);

    always_comb begin
        ar_go     = !reset && r_state_q == R_IDLE && ar_hit;
        r_go      = !reset && r_state_q == R_WAIT;
        m.arready = !reset && r_state_q == R_IDLE && (ar_hit ? s_arready[ar_sel] : 1'b1);
        m.rvalid  = !reset && (r_state_q == R_ERR || (r_go && s_rvalid[sel_r_q]));
        m.rdata   = r_go ? s_rdata[sel_r_q] : '0;
        m.rresp   = r_state_q == R_ERR ? 2'b11 : r_go ? s_rresp[sel_r_q] : 2'b00;
        // AW and W are only considered in IDLE once an address is on the bus.
        w_idle    = !reset && w_state_q == W_IDLE && m.awvalid;
        w_xfer    = !reset && w_state_q == W_XFER && !err_q;
        w_xerr    = !reset && w_state_q == W_XFER && err_q;
        ws        = w_state_q == W_IDLE ? aw_sel : sel_w_q;
        aw_go     = (w_idle && aw_hit) || (w_xfer && !aw_done_q);
        wd_go     = (w_idle && aw_hit) || (w_xfer && !w_done_q);
        m.awready = aw_go ? s_awready[ws] : (w_idle && !aw_hit) || (w_xerr && !aw_done_q);
        m.wready  = wd_go ? s_wready[ws] : (w_idle && !aw_hit) || (w_xerr && !w_done_q);
        b_go      = !reset && w_state_q == W_RESP;
        m.bvalid  = (!reset && w_state_q == W_ERR) || (b_go && s_bvalid[sel_w_q]);
        m.bresp   = w_state_q == W_ERR ? 2'b11 : b_go ? s_bresp[sel_w_q] : 2'b00;
    end

    for (genvar i = 0; i < NS; i++) begin : g_slv
        localparam logic [SW-1:0] IDX = SW'(i);
        assign s[i].araddr  = m.araddr;
        assign s[i].arvalid = ar_go && m.arvalid && ar_sel == IDX;
        assign s[i].rready  = r_go && m.rready && sel_r_q == IDX;
        assign s[i].awaddr  = m.awaddr;
        assign s[i].awvalid = aw_go && m.awvalid && ws == IDX;
        assign s[i].wdata   = m.wdata;
        assign s[i].wmask   = m.wmask;
        assign s[i].wvalid  = wd_go && m.wvalid && ws == IDX;
        assign s[i].bready  = b_go && m.bready && sel_w_q == IDX;
        assign s_arready[i] = s[i].arready;
        assign s_rvalid[i]  = s[i].rvalid;
        assign s_rdata[i]   = s[i].rdata;
        assign s_rresp[i]   = s[i].rresp;
        assign s_awready[i] = s[i].awready;
        assign s_wready[i]  = s[i].wready;
        assign s_bvalid[i]  = s[i].bvalid;
        assign s_bresp[i]   = s[i].bresp;
    end

    always_comb begin
        ar_hs     = m.arvalid && m.arready;
        r_hs      = m.rvalid && m.rready;
        aw_hs     = m.awvalid && m.awready;
        w_hs      = m.wvalid && m.wready;
        b_hs      = m.bvalid && m.bready;
        r_state_d = r_state_q;
        sel_r_d   = sel_r_q;
        if (r_state_q == R_IDLE && ar_hs) begin
            r_state_d = ar_hit ? R_WAIT : R_ERR;
            sel_r_d   = ar_sel;
        end
        if (r_state_q != R_IDLE && r_hs) r_state_d = R_IDLE;
        w_state_d = w_state_q;
        sel_w_d   = sel_w_q;
        err_d     = err_q;
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (w_state_q == W_IDLE && (aw_hs || w_hs)) begin
            sel_w_d   = aw_sel;
            err_d     = !aw_hit;
            w_state_d = !(aw_done_d && w_done_d) ? W_XFER : aw_hit ? W_RESP : W_ERR;
        end
        if (w_state_q == W_XFER && aw_done_d && w_done_d) w_state_d = err_q ? W_ERR : W_RESP;
        if ((w_state_q == W_RESP || w_state_q == W_ERR) && b_hs) begin
            w_state_d = W_IDLE;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            sel_r_q   <= '0;
            w_state_q <= W_IDLE;
            sel_w_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            sel_r_q   <= sel_r_d;
            w_state_q <= w_state_d;
            sel_w_q   <= sel_w_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

`ifdef AXI_XBAR_DIFFTEST_SKIP_EN
    logic skip_q, skip_d;
    // Read and write completions merge into one pulse; DECERR states never qualify.
    assign skip_d = (r_state_q == R_WAIT && r_hs && SLV_IS_DEV[sel_r_q])
                 || (w_state_q == W_RESP && b_hs && SLV_IS_DEV[sel_w_q]);
    always_ff @(posedge clk) skip_q <= !reset && skip_d;
    assign difftest_skip = skip_q;
`endif
endmodule
